// File: rtl/match_sweeper.sv
// Re-issues DNA pattern searches until the region is exhausted, storing every hit in a small buffer.
// go -> srch_ready next cycle; srch_done -> next srch_ready two cycles later; one search outstanding, no flow control.
module match_sweeper #(
    parameter int MAX_HITS   = 8,
    parameter int WAIT_LIMIT = 1023
) (
    input  logic                          clock,
    input  logic                          reset_N,
    input  logic                          go,
    input  logic                          abort,
    input  logic [15:0]                   region_start,
    input  logic [15:0]                   region_length,
    input  logic [11:0]                   pattern_start,
    output logic                          srch_ready,
    output logic [15:0]                   srch_dna_start,
    output logic [15:0]                   srch_dna_length,
    output logic [11:0]                   srch_pattern_start,
    input  logic                          srch_done,
    input  logic                          srch_found_it,
    input  logic                          srch_error,
    input  logic [15:0]                   srch_found_location,
    output logic [$clog2(MAX_HITS+1)-1:0] hit_count,
    input  logic [$clog2(MAX_HITS)-1:0]   rd_idx,
    output logic [15:0]                   rd_loc,
    output logic                          sweep_done,
    output logic                          sweep_error,
    output logic                          overflow
);
    localparam int HCW = $clog2(MAX_HITS + 1);
    localparam int RIW = $clog2(MAX_HITS);
    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        RECORD = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [15:0]    cur_start;
    logic [15:0]    region_end;
    logic [WCW-1:0] wait_cnt;
    logic           cap_found;
    logic           cap_error;
    logic [15:0]    cap_loc;
    logic [15:0]    hit_mem [MAX_HITS];

    logic           start_sweep;
    logic           wait_timeout;
    logic           hits_full;
    logic           rec_active;
    logic           rec_store;
    logic           rec_continue;
    logic [15:0]    next_start;

    assign start_sweep  = ((state == IDLE) || (state == DONE)) && go && !abort;
    assign wait_timeout = (state == WAIT) && !srch_done && (wait_cnt == WCW'(WAIT_LIMIT - 1));
    assign hits_full    = (hit_count == HCW'(MAX_HITS));
    assign rec_active   = (state == RECORD) && !abort;
    assign rec_store    = cap_found && !cap_error && !hits_full;
    assign next_start   = cap_loc + 16'd1;
    // Location FFFF would wrap next_start to 0 and look like an in-range restart.
    assign rec_continue = rec_store && (cap_loc != 16'hFFFF) && (next_start < region_end);

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE)) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state_nxt = (region_length == 16'd0) ? DONE : ISSUE;
                    end
                end
                ISSUE: state_nxt = WAIT;
                WAIT: begin
                    if (srch_done) begin
                        state_nxt = RECORD;
                    end else if (wait_timeout) begin
                        state_nxt = DONE;
                    end
                end
                RECORD:  state_nxt = rec_continue ? ISSUE : DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign srch_ready      = (state == ISSUE);
    assign sweep_done      = (state == DONE);
    assign srch_dna_start  = cur_start;
    assign srch_dna_length = region_end;

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            cur_start          <= '0;
            region_end         <= '0;
            srch_pattern_start <= '0;
            hit_count          <= '0;
            sweep_error        <= 1'b0;
            overflow           <= 1'b0;
            wait_cnt           <= '0;
            cap_found          <= 1'b0;
            cap_error          <= 1'b0;
            cap_loc            <= '0;
        end else begin
            if (start_sweep) begin
                cur_start          <= region_start;
                region_end         <= region_start + region_length;
                srch_pattern_start <= pattern_start;
                hit_count          <= '0;
                sweep_error        <= 1'b0;
                overflow           <= 1'b0;
            end

            if (state == ISSUE) begin
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WCW'(1);
            end

            if ((state == WAIT) && srch_done) begin
                cap_found <= srch_found_it;
                cap_error <= srch_error;
                cap_loc   <= srch_found_location;
            end

            if (wait_timeout && !abort) begin
                sweep_error <= 1'b1;
            end

            if (rec_active) begin
                if (cap_error) begin
                    sweep_error <= 1'b1;
                end else if (cap_found && hits_full) begin
                    overflow <= 1'b1;
                end else if (rec_store) begin
                    hit_count <= hit_count + HCW'(1);
                end
                if (rec_continue) begin
                    cur_start <= next_start;
                end
            end
        end
    end

    // Buffer needs no reset: entries at or above hit_count are never readable.
    always_ff @(posedge clock) begin
        if (rec_active && rec_store) begin
            hit_mem[hit_count[RIW-1:0]] <= cap_loc;
        end
    end

    always_comb begin
        rd_loc = '0;
        if (HCW'(rd_idx) < hit_count) begin
            rd_loc = hit_mem[rd_idx];
        end
    end
endmodule

// File: tb/tb_match_sweeper.sv
// Randomized bench for match_sweeper: a searcher model answers each issued search from a list of
// match addresses, and a reference model derives the expected start sequence, hits and flags.
module tb_match_sweeper;
    localparam int MAX_HITS   = 8;
    localparam int WAIT_LIMIT = 1023;

    logic        clock;
    logic        reset_N;
    logic        go;
    logic        abort;
    logic [15:0] region_start;
    logic [15:0] region_length;
    logic [11:0] pattern_start;
    logic        srch_ready;
    logic [15:0] srch_dna_start;
    logic [15:0] srch_dna_length;
    logic [11:0] srch_pattern_start;
    logic        srch_done;
    logic        srch_found_it;
    logic        srch_error;
    logic [15:0] srch_found_location;
    logic [3:0]  hit_count;
    logic [2:0]  rd_idx;
    logic [15:0] rd_loc;
    logic        sweep_done;
    logic        sweep_error;
    logic        overflow;

    match_sweeper #(.MAX_HITS(MAX_HITS), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clock(clock), .reset_N(reset_N), .go(go), .abort(abort),
        .region_start(region_start), .region_length(region_length), .pattern_start(pattern_start),
        .srch_ready(srch_ready), .srch_dna_start(srch_dna_start), .srch_dna_length(srch_dna_length),
        .srch_pattern_start(srch_pattern_start), .srch_done(srch_done), .srch_found_it(srch_found_it),
        .srch_error(srch_error), .srch_found_location(srch_found_location), .hit_count(hit_count),
        .rd_idx(rd_idx), .rd_loc(rd_loc), .sweep_done(sweep_done), .sweep_error(sweep_error),
        .overflow(overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_chk = 0;
    int n_err = 0;
    bit noise = 1'b0;
    int match_q[$];
    int exp_starts[$];
    int exp_hits[$];
    bit exp_ovf;
    bit exp_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Mid-sweep the control inputs are scrambled; the sweeper must ignore them until DONE.
    task automatic tick();
        @(negedge clock);
        if (noise && !sweep_done) begin
            go            = 1'($urandom);
            region_start  = 16'($urandom);
            region_length = 16'($urandom);
            pattern_start = 12'($urandom);
        end else begin
            go = 1'b0;
        end
    endtask

    // Reference: every match in [rs, rs+rl) is found in order; each hit restarts the search one past it.
    task automatic build_expect(input int rs, input int rl, input int err_on);
        int re;
        int cur;
        int nxt;
        re  = rs + rl;
        cur = rs;
        exp_starts.delete();
        exp_hits.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        if (rl == 0) return;
        forever begin
            exp_starts.push_back(cur);
            if (err_on == exp_starts.size()) begin
                exp_err = 1'b1;
                return;
            end
            nxt = -1;
            foreach (match_q[i]) if (nxt < 0 && match_q[i] >= cur && match_q[i] < re) nxt = match_q[i];
            if (nxt < 0) return;
            if (exp_hits.size() == MAX_HITS) begin
                exp_ovf = 1'b1;
                return;
            end
            exp_hits.push_back(nxt);
            if (nxt + 1 >= re) return;
            cur = nxt + 1;
        end
    endtask

    task automatic run_sweep(input string nm, input int rs, input int rl, input int err_on, input int max_lat);
        logic [11:0] ps;
        int n_iss;
        int guard;
        int loc;
        bit fnd;
        build_expect(rs, rl, err_on);
        ps = 12'($urandom);
        @(negedge clock);
        region_start  = 16'(rs);
        region_length = 16'(rl);
        pattern_start = ps;
        go            = 1'b1;
        @(negedge clock);
        go = 1'b0;
        if (rl == 0) begin
            check({nm, "/zero_ready"}, srch_ready, 0);
            check({nm, "/zero_done"}, sweep_done, 1);
        end
        n_iss = 0;
        guard = 0;
        while (!sweep_done && guard < 40) begin
            guard++;
            check({nm, "/ready"}, srch_ready, 1);
            if (n_iss < exp_starts.size()) check({nm, "/start"}, srch_dna_start, exp_starts[n_iss]);
            check({nm, "/length"}, srch_dna_length, 32'(rs + rl));
            check({nm, "/pattern"}, srch_pattern_start, ps);
            n_iss++;
            fnd = 1'b0;
            loc = 0;
            foreach (match_q[i]) begin
                if (!fnd && match_q[i] >= int'(srch_dna_start) && match_q[i] < int'(srch_dna_length)) begin
                    fnd = 1'b1;
                    loc = match_q[i];
                end
            end
            tick();
            check({nm, "/one_shot"}, srch_ready, 0);
            repeat ($urandom_range(0, max_lat)) tick();
            srch_done           = 1'b1;
            srch_error          = (n_iss == err_on);
            srch_found_it       = fnd;
            srch_found_location = 16'(loc);
            tick();
            srch_done           = 1'b0;
            srch_found_it       = 1'($urandom);
            srch_error          = 1'($urandom);
            srch_found_location = 16'($urandom);
            check({nm, "/record_ready"}, srch_ready, 0);
            tick();
            if (n_iss < exp_starts.size()) check({nm, "/reissue"}, srch_ready, 1);
            else check({nm, "/done_lat"}, sweep_done, 1);
        end
        check({nm, "/issued"}, n_iss, exp_starts.size());
        check({nm, "/done"}, sweep_done, 1);
        check({nm, "/hits"}, hit_count, exp_hits.size());
        check({nm, "/overflow"}, overflow, exp_ovf);
        check({nm, "/error"}, sweep_error, exp_err);
        for (int i = 0; i < MAX_HITS; i++) begin
            rd_idx = 3'(i);
            #1;
            check({nm, "/rd_loc"}, rd_loc, (i < exp_hits.size()) ? exp_hits[i] : 0);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        int rs;
        int rl;
        int n;
        reset_N = 1'b0; go = 1'b0; abort = 1'b0;
        region_start = '0; region_length = '0; pattern_start = '0;
        srch_done = 1'b0; srch_found_it = 1'b0; srch_error = 1'b0; srch_found_location = '0;
        rd_idx = '0;
        repeat (3) @(negedge clock);
        check("rst/ready", srch_ready, 0);
        check("rst/done", sweep_done, 0);
        check("rst/error", sweep_error, 0);
        check("rst/overflow", overflow, 0);
        check("rst/hits", hit_count, 0);
        check("rst/start", srch_dna_start, 0);
        check("rst/length", srch_dna_length, 0);
        check("rst/rd_loc", rd_loc, 0);
        reset_N = 1'b1;

        match_q = '{90, 105, 120, 140, 160};
        run_sweep("basic", 100, 50, 0, 4);
        match_q = '{5};
        run_sweep("zero", 5, 0, 0, 0);
        match_q.delete();
        for (int i = 0; i < 20; i++) match_q.push_back(i);
        run_sweep("ovf", 0, 100, 0, 2);
        match_q = '{9, 12};
        run_sweep("endhit", 0, 10, 0, 3);
        match_q = '{310, 320};
        run_sweep("err2", 300, 50, 2, 3);

        // go and abort together while in DONE: abort wins.
        @(negedge clock); abort = 1'b1; go = 1'b1;
        @(negedge clock); abort = 1'b0; go = 1'b0;
        check("done_abort/done", sweep_done, 0);
        check("done_abort/ready", srch_ready, 0);

        // Searcher never answers: timeout after WAIT_LIMIT cycles in WAIT.
        region_start = 16'd200; region_length = 16'd20; go = 1'b1;
        @(negedge clock); go = 1'b0;
        check("to/ready", srch_ready, 1);
        repeat (WAIT_LIMIT) @(negedge clock);
        check("to/not_yet", sweep_done, 0);
        @(negedge clock);
        check("to/done", sweep_done, 1);
        check("to/error", sweep_error, 1);
        check("to/hits", hit_count, 0);

        // Reset while waiting; a late srch_done must be ignored.
        region_start = 16'd1000; region_length = 16'd30; pattern_start = 12'h5A5; go = 1'b1;
        @(negedge clock); go = 1'b0;
        @(negedge clock);
        @(negedge clock); reset_N = 1'b0;
        @(negedge clock); reset_N = 1'b1;
        check("mrst/ready", srch_ready, 0);
        check("mrst/done", sweep_done, 0);
        check("mrst/start", srch_dna_start, 0);
        check("mrst/length", srch_dna_length, 0);
        check("mrst/pattern", srch_pattern_start, 0);
        srch_done = 1'b1; srch_found_it = 1'b1; srch_found_location = 16'd1005;
        @(negedge clock); srch_done = 1'b0; srch_found_it = 1'b0;
        repeat (2) @(negedge clock);
        check("mrst/late_ready", srch_ready, 0);
        check("mrst/late_hits", hit_count, 0);
        check("mrst/late_done", sweep_done, 0);

        // Abort with go during the second search.
        region_start = 16'd0; region_length = 16'd100; go = 1'b1;
        @(negedge clock); go = 1'b0;
        @(negedge clock);
        srch_done = 1'b1; srch_found_it = 1'b1; srch_error = 1'b0; srch_found_location = 16'd5;
        @(negedge clock); srch_done = 1'b0;
        @(negedge clock);
        check("abort/reissue", srch_ready, 1);
        check("abort/start", srch_dna_start, 6);
        @(negedge clock); abort = 1'b1; go = 1'b1;
        @(negedge clock); abort = 1'b0; go = 1'b0;
        check("abort/done", sweep_done, 0);
        check("abort/ready", srch_ready, 0);
        check("abort/hits", hit_count, 1);
        rd_idx = 3'd0;
        #1;
        check("abort/rd_loc", rd_loc, 5);
        repeat (3) @(negedge clock);
        check("abort/idle_ready", srch_ready, 0);
        check("abort/idle_done", sweep_done, 0);

        noise = 1'b1;
        for (int it = 0; it < 30; it++) begin
            rs = $urandom_range(0, 60000);
            rl = $urandom_range(0, 120);
            n  = (it % 5 == 0) ? 14 : $urandom_range(0, 10);
            match_q.delete();
            for (int k = 0; k < n; k++) match_q.push_back(rs + $urandom_range(0, rl + 10));
            match_q.sort();
            run_sweep("rand", rs, rl, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, 5);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
